// File: rtl/mdu_pkg.sv
// mdu_pkg: operation codes, write-back/instruction-type tags and FSM state type
// shared by the multiply/divide unit, the decoder and the stall controller.
// Pure declarations; no logic.
package mdu_pkg;

  // MDU operation codes carried from decode to the E stage
  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MTHI  = 4'd5;
  localparam logic [3:0] MDU_MTLO  = 4'd6;
  localparam logic [3:0] MDU_MFHI  = 4'd7;
  localparam logic [3:0] MDU_MFLO  = 4'd8;

  // Write-back source selecting the MDU read result (mfhi/mflo) in W
  localparam logic [2:0] REGWR_MDU = 3'd4;

  // Instruction class used by the stall controller for HI/LO-dependent ops
  localparam logic [3:0] INSTR_MDU = 4'd7;

  // Control state of the unit
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_t;

  function automatic logic is_mul_op(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational 64-bit multiply/divide result from the latched op/operands.
// Latency: zero (pure combinational); the owning FSM decides when to commit.
// Divider present only when MDU_DIV_EN is defined; otherwise div/divu never commit.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        commit,
  output logic        div_en
);

  logic        mul_signed;
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] product;

  // One shared 64-bit multiplier; sign extension picks mult vs multu
  always_comb begin
    mul_signed = (op == MDU_MULT);
    mul_a      = mul_signed ? {{32{a[31]}}, a} : {32'h0, a};
    mul_b      = mul_signed ? {{32{b[31]}}, b} : {32'h0, b};
    product    = mul_a * mul_b;
  end

`ifdef MDU_DIV_EN
  logic        div_signed;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] dvd;
  logic [31:0] dvs;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  // Divide magnitudes with one unsigned divider, then restore signs:
  // quotient truncates toward zero, remainder follows the dividend.
  // 0x80000000 / -1 falls out naturally as 0x80000000 rem 0.
  always_comb begin
    div_signed = (op == MDU_DIV);
    a_neg      = div_signed & a[31];
    b_neg      = div_signed & b[31];
    dvd        = a_neg ? (~a + 32'd1) : a;
    dvs        = b_neg ? (~b + 32'd1) : b;
    // A zero divisor never commits; substitute 1 so the divider stays defined
    if (dvs == 32'h0) dvs = 32'd1;
    q_mag      = dvd / dvs;
    r_mag      = dvd % dvs;
    quot       = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    rem        = a_neg ? (~r_mag + 32'd1) : r_mag;
  end

  assign div_en = 1'b1;
`else
  assign div_en = 1'b0;
`endif

  // Result select and commit qualification (divide by zero leaves HI/LO alone)
  always_comb begin
    result = product;
    commit = is_mul_op(op);
`ifdef MDU_DIV_EN
    if (is_div_op(op)) begin
      result = {rem, quot};
      commit = (b != 32'h0);
    end
`endif
  end

endmodule

// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit with private HI/LO for the E stage.
// Latency: mult MULT_CYCLES, div DIV_CYCLES busy cycles; mthi/mtlo 1 edge; rd_data combinational.
// No handshake: start while busy is ignored; stall control holds dependants on busy.
// Optional divider enabled by defining MDU_DIV_EN.
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd_data
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  mdu_state_t  state;
  mdu_state_t  state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic        load;
  logic        finish;
  logic        issue_mul;
  logic        issue_div;
  logic [3:0]  lat_op;
  logic [31:0] lat_a;
  logic [31:0] lat_b;
  logic [63:0] arith_res;
  logic        arith_wr;
  logic        div_en;

  mdu_arith u_arith (
    .op     (lat_op),
    .a      (lat_a),
    .b      (lat_b),
    .result (arith_res),
    .commit (arith_wr),
    .div_en (div_en)
  );

  // Decode which long operations can start this cycle
  always_comb begin
    issue_mul = start && is_mul_op(op);
    issue_div = start && div_en && is_div_op(op);
  end

  // Next-state: load the counter on issue, count down in RUN, finish on 1->0
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    load     = 1'b0;
    finish   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (issue_mul || issue_div) begin
          load     = 1'b1;
          state_nx = ST_RUN;
          cnt_nx   = issue_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
        end
      end
      ST_RUN: begin
        cnt_nx = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          finish   = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // State and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Capture op and operands at issue so the forwarding path may change freely
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_op <= MDU_NONE;
      lat_a  <= '0;
      lat_b  <= '0;
    end else if (load) begin
      lat_op <= op;
      lat_a  <= a;
      lat_b  <= b;
    end
  end

  // HI/LO: commit at end of a long op, or direct moves while idle
  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (finish) begin
      if (arith_wr) begin
        hi <= arith_res[63:32];
        lo <= arith_res[31:0];
      end
    end else if (state == ST_IDLE && start) begin
      if (op == MDU_MTHI) hi <= a;
      if (op == MDU_MTLO) lo <= a;
    end
  end

  // Outputs: busy flag and zero-latency HI/LO read port
  always_comb begin
    busy = (state == ST_RUN);
    unique case (op)
      MDU_MFHI: rd_data = hi;
      MDU_MFLO: rd_data = lo;
      default:  rd_data = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: randomized and directed stimulus for mdu with a scoreboard of expected
// busy length and HI/LO per long operation, checked when busy falls.
module tb_mdu;
  import mdu_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rd_data;

  always #5 clk = ~clk;

  mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo),
    .rd_data (rd_data)
  );

  typedef struct {
    int          n;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sb[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] m_hi   = 32'h0;
  logic [31:0] m_lo   = 32'h0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference behaviour from the architectural definition of each op
  function automatic void model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                inout logic [31:0] h, inout logic [31:0] l, output int n);
    int sx;
    int sy;
    n  = 0;
    sx = x;
    sy = y;
    case (o)
      MDU_MULT: begin
        longint p;
        p = longint'(sx) * longint'(sy);
        h = p[63:32];
        l = p[31:0];
        n = MC;
      end
      MDU_MULTU: begin
        logic [63:0] u;
        u = {32'h0, x} * {32'h0, y};
        h = u[63:32];
        l = u[31:0];
        n = MC;
      end
`ifdef MDU_DIV_EN
      MDU_DIV: begin
        longint q;
        longint r;
        n = DC;
        if (y != 32'h0) begin
          q = longint'(sx) / longint'(sy);
          r = longint'(sx) % longint'(sy);
          l = q[31:0];
          h = r[31:0];
        end
      end
      MDU_DIVU: begin
        n = DC;
        if (y != 32'h0) begin
          l = x / y;
          h = x % y;
        end
      end
`endif
      MDU_MTHI: h = x;
      MDU_MTLO: l = x;
      default: ;
    endcase
  endfunction

  // Issue one op; during busy, scramble operands and optionally poke an mthi
  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, input int poke);
    int          n;
    logic [31:0] h;
    logic [31:0] l;
    h = m_hi;
    l = m_lo;
    model(o, x, y, h, l, n);
    if (n > 0) sb.push_back('{n, h, l});
    start = 1'b1; op = o; a = x; b = y;
    cyc();
    start = 1'b0; op = MDU_NONE;
    chk("busy_after_issue", busy, n > 0);
    for (int i = 1; i <= n + 4 && busy; i++) begin
      a = $urandom;
      b = $urandom;
      if (i == poke) begin
        start = 1'b1; op = MDU_MTHI; a = 32'hDEAD;
      end
      cyc();
      start = 1'b0; op = MDU_NONE;
    end
    chk("busy_timeout", busy, 0);
    m_hi = h;
    m_lo = l;
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    op = MDU_MFHI; #1;
    chk("rd_mfhi", rd_data, m_hi);
    op = MDU_MFLO; #1;
    chk("rd_mflo", rd_data, m_lo);
    op = MDU_NONE; #1;
    chk("rd_none", rd_data, 0);
  endtask

  // Reset on the third busy cycle must abort with no late commit
  task automatic abort_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    cyc();
    start = 1'b0; op = MDU_NONE;
    chk("abort_busy_c1", busy, 1);
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    repeat (DC + 3) cyc();
    chk("abort_late_busy", busy, 0);
    chk("abort_late_hi", hi, 0);
    chk("abort_late_lo", lo, 0);
    m_hi = 32'h0;
    m_lo = 32'h0;
  endtask

  // Monitor: on each busy fall, pop the expected commit and compare
  logic prev_busy  = 1'b0;
  logic prev_reset = 1'b0;
  int   blen       = 0;
  always @(negedge clk) begin
    if (prev_busy && !busy && !prev_reset) begin
      if (sb.size() == 0) begin
        chk("unexpected_busy_fall", sb.size(), 1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_busy_len", blen, e.n);
        chk("sb_hi", hi, e.hi);
        chk("sb_lo", lo, e.lo);
      end
    end else if (prev_busy && !busy && prev_reset) begin
      void'(sb.pop_front());
    end
    blen       = busy ? blen + 1 : 0;
    prev_busy  = busy;
    prev_reset = reset;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; op = MDU_MFHI; a = '0; b = '0;
    repeat (3) cyc();
    chk("rst_busy", busy, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_rd", rd_data, 0);
    reset = 1'b0; op = MDU_NONE;
    cyc();

    issue(MDU_MULT,  32'hFFFFFFFE, 32'd3, 0);
    issue(MDU_DIV,   32'hFFFFFFF9, 32'd2, 0);
    issue(MDU_DIVU,  32'd7, 32'd2, 0);
    issue(MDU_MTHI,  32'h11, 32'h0, 0);
    issue(MDU_MTLO,  32'h22, 32'h0, 0);
    issue(MDU_DIVU,  32'd5, 32'd0, 0);
    issue(MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 2);
    issue(MDU_MULT,  32'd6, 32'd7, 0);
    issue(MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 0);
    issue(MDU_DIV,   32'd100, 32'd7, 0);
    issue(MDU_MTHI,  32'h55, 32'h0, 0);
    issue(MDU_MTLO,  32'h66, 32'h0, 0);
`ifdef MDU_DIV_EN
    abort_op(MDU_DIV, 32'd100, 32'd7);
`else
    abort_op(MDU_MULT, 32'd100, 32'd7);
`endif

    for (int k = 0; k < 40; k++) begin
      logic [3:0]  o;
      logic [31:0] x;
      logic [31:0] y;
      o = 4'($urandom_range(0, 8));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 5))
        0: y = 32'h0;
        1: begin x = 32'($urandom_range(0, 200)); y = 32'($urandom_range(1, 20)); end
        2: y = 32'hFFFFFFFF;
        default: ;
      endcase
      issue(o, x, y, ($urandom_range(0, 2) == 0) ? 1 : 0);
    end

    repeat (3) cyc();
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit for the execute stage of the five-stage MIPS pipeline. It accepts `mult`, `multu`, `div`, `divu`, `mthi`, `mtlo`, `mfhi` and `mflo` from the E stage. Multiply and divide run for a fixed number of cycles and commit their result to private HI/LO registers. A `busy` flag tells the stall controller to hold any HI/LO-dependent instruction in D until the result is committed.

## Interface

Parameters:
- `MULT_CYCLES`, default 5. Busy cycles for `mult`/`multu`. Minimum 1.
- `DIV_CYCLES`, default 10. Busy cycles for `div`/`divu`. Minimum 1.

Ports:
- `clk`, input, 1. Single clock; all state updates on the rising edge.
- `reset`, input, 1. Synchronous, active-high.
- `start`, input, 1. The E-stage instruction is an MDU instruction. Qualifies `op`.
- `op`, input, 4. `MDU_*` operation code.
- `a`, input, 32. rs operand, already forwarded (V1 after E-stage forward).
- `b`, input, 32. rt operand, already forwarded (V2 after E-stage forward).
- `busy`, output, 1. A multiply or divide is in progress.
- `hi`, output, 32. Current HI register.
- `lo`, output, 32. Current LO register.
- `rd_data`, output, 32. Combinational read result. Selects `hi` when `op`=`MDU_MFHI` and `lo` when `op`=`MDU_MFLO`; otherwise 0.

## Operation

- Reset: `hi`=0, `lo`=0, `busy`=0, counter=0. Any pending operation is discarded.
- States:
  - IDLE, entered when counter==0.
  - RUN, entered when counter>0.
- Transitions out of IDLE when `start` is high:
  - `MDU_MULT`, `MDU_MULTU`: latch `a`, `b` and `op`; load counter with `MULT_CYCLES`; enter RUN.
  - `MDU_DIV`, `MDU_DIVU`: same as multiply, but load counter with `DIV_CYCLES`.
  - `MDU_MTHI`: `hi` ← `a` at this edge. Not busy.
  - `MDU_MTLO`: `lo` ← `a` at this edge. Not busy.
  - `MDU_MFHI`, `MDU_MFLO`, `MDU_NONE`: no state change.
- In RUN, the counter decrements every cycle. On the edge where it goes 1→0:
  - HI/LO are written from the latched operands.
  - The block returns to IDLE.
- Arithmetic, always on the latched operands:
  - `mult`: {hi,lo} = signed 32×32 → 64.
  - `multu`: {hi,lo} = unsigned 32×32 → 64.
  - `div`: lo = quotient, truncated toward zero; hi = remainder, with the sign of the dividend.
  - `divu`: unsigned quotient in lo, unsigned remainder in hi.
- Boundary cases:
  - Divisor 0 (signed or unsigned): full `DIV_CYCLES` busy period, then HI/LO unchanged.
  - `div` 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - `start` while `busy` (any op, including mt*): ignored, no state change. The stall controller must prevent it. The bench checks that it is ignored.
  - `reset` in RUN: aborts, counter=0, HI/LO cleared. No late commit.
- Pipeline contract: the stall controller stalls D whenever the D instruction is an MDU type and either (`busy` or (`start` and op ∈ {mult, multu, div, divu})).

## Timing

- Multiply or divide issued with `start` in cycle T:
  - `busy`=1 in cycles T+1 … T+N, where N is `MULT_CYCLES` or `DIV_CYCLES`.
  - HI/LO carry the new value from cycle T+N+1, the same cycle `busy` falls.
- `mthi` or `mtlo` in cycle T: new value visible on `hi`/`lo` from T+1. `busy` never asserts.
- `rd_data` has zero latency from `op`, `hi` and `lo`. In cycle T it returns the registered HI/LO.
  - An `mthi` in cycle T is therefore seen by `mfhi` in cycle T+1 and later, never in T.
- Back-to-back: a new `start` is accepted in the first IDLE cycle, T+N+1.

## Configuration

- `MDU_DIV_EN` defined: `div` and `divu` are implemented as described.
- `MDU_DIV_EN` undefined:
  - No divider logic is synthesised.
  - `MDU_DIV` and `MDU_DIVU` are treated as `MDU_NONE`: no busy, HI/LO unchanged.
  - `DIV_CYCLES` is unused.

## Structure

- Shared constants go in `Constants.v`:
  - `MDU_NONE`=0, `MDU_MULT`=1, `MDU_MULTU`=2, `MDU_DIV`=3, `MDU_DIVU`=4, `MDU_MTHI`=5, `MDU_MTLO`=6, `MDU_MFHI`=7, `MDU_MFLO`=8.
  - A new `REGWr_Mdu` write-back source so `rd_data` is piped to W.
  - A new instruction type for MDU, used by StallCtrl.
- One sub-module, `mdu_arith`: combinational 64-bit result from the latched op and operands. Contains the `MDU_DIV_EN` guard.
- The counter, latches and HI/LO registers live in `mdu`.

## Test plan

- **Signed multiply:** `mult` a=0xFFFFFFFE (−2), b=3.
  - `busy`=1 for exactly 5 cycles.
  - Then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- **Signed divide:** `div` a=−7 (0xFFFFFFF9), b=2.
  - 10 busy cycles.
  - Then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - Repeat with `divu` 7/2: lo=3, hi=1.
- **Divide by zero, then move to HI/LO:**
  - Preload via `mthi` 0x11, `mtlo` 0x22.
  - `divu` a=5, b=0 → 10 busy cycles, then hi=0x11, lo=0x22.
  - `mflo` in the next cycle → `rd_data`=0x22.
- **Start while busy:** `multu` 0xFFFFFFFF×0xFFFFFFFF.
  - During busy, pulse `start` with `mthi` a=0xDEAD → ignored.
  - Final hi=0xFFFFFFFE, lo=0x00000001.
- **Reset mid-operation:** `reset` asserted on busy cycle 3 of a `div` 100/7.
  - Next cycle `busy`=0, hi=lo=0.
  - No commit afterwards.
- **Operand hold:** change `a`/`b` every cycle during a `mult` 6×7 → lo=42, hi=0.
  - Rebuild without `MDU_DIV_EN`: `div` 100/7 → `busy` never rises, HI/LO unchanged.
